// File: rtl/rx_frame_readout_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rx_frame_readout_ctrl                                            |
// | Brief   : Per-frame read-out sequencer between the receive FIFO and a      |
// |           valid/ready byte stream; discards bad-CRC and empty frames.      |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module rx_frame_readout_ctrl #(
    parameter int LEN_W      = 11,
    parameter int DESC_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_wr_en,
    input  logic             frame_complete,
    input  logic             crc_valid,
    input  logic             crc_ok,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_data_out,
    output logic             fifo_rd_en,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_drop,
    output logic             err_desc_ovf
);

    localparam int               c_aw      = $clog2(DESC_DEPTH);
    localparam logic [LEN_W-1:0] c_len_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [c_aw:0]    c_depth   = (c_aw + 1)'(DESC_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DROP  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Per-frame byte counter
    // ------------------------------------------------------------------
    logic [LEN_W-1:0] r_byte_cnt;
    logic [LEN_W-1:0] r_len_hold;
    logic [LEN_W-1:0] w_cnt_inc;
    logic [LEN_W-1:0] w_desc_len;

    assign w_cnt_inc  = (fifo_wr_en && (r_byte_cnt != c_len_max)) ?
                        r_byte_cnt + LEN_W'(1) : r_byte_cnt;
    // A CRC result arriving with the frame end must see the length just counted.
    assign w_desc_len = frame_complete ? w_cnt_inc : r_len_hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_byte_cnt <= '0;
            r_len_hold <= '0;
        end else if (frame_complete) begin
            r_len_hold <= w_cnt_inc;
            r_byte_cnt <= '0;
        end else begin
            r_byte_cnt <= w_cnt_inc;
        end
    end

    // ------------------------------------------------------------------
    // Descriptor queue {length, crc_ok}
    // ------------------------------------------------------------------
    logic [LEN_W:0]   r_q_mem [DESC_DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_q_cnt;
    logic             w_q_full;
    logic             w_q_empty;
    logic             w_push;
    logic             w_pop;
    logic [LEN_W-1:0] w_head_len;
    logic             w_head_ok;

    assign w_q_full   = (r_q_cnt == c_depth);
    assign w_q_empty  = (r_q_cnt == '0);
    assign w_push     = crc_valid && (!w_q_full || w_pop);
    assign w_head_len = r_q_mem[r_rd_ptr][LEN_W:1];
    assign w_head_ok  = r_q_mem[r_rd_ptr][0];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_mem[r_wr_ptr] <= {w_desc_len, crc_ok};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_q_cnt      <= '0;
            err_desc_ovf <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_q_cnt <= r_q_cnt + (c_aw + 1)'(1);
                2'b01:   r_q_cnt <= r_q_cnt - (c_aw + 1)'(1);
                default: r_q_cnt <= r_q_cnt;
            endcase
            if (crc_valid && !w_push) begin
                err_desc_ovf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read-out FSM
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_rem;
    logic [LEN_W-1:0] w_rem_nxt;
    logic [7:0]       r_m_data;
    logic [7:0]       w_data_nxt;
    logic             r_m_valid;
    logic             w_valid_nxt;
    logic             r_m_last;
    logic             w_last_nxt;
    logic             w_rd_en;
    logic             w_ok_inc;
    logic             w_drop_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_rem     <= '0;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rem     <= w_rem_nxt;
            r_m_data  <= w_data_nxt;
            r_m_valid <= w_valid_nxt;
            r_m_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_data_nxt  = r_m_data;
        w_valid_nxt = r_m_valid;
        w_last_nxt  = r_m_last;
        w_pop       = 1'b0;
        w_rd_en     = 1'b0;
        w_ok_inc    = 1'b0;
        w_drop_inc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_q_empty) begin
                    w_pop       = 1'b1;
                    w_rem_nxt   = w_head_len;
                    w_state_nxt = (w_head_ok && (w_head_len != '0)) ? S_FETCH : S_DROP;
                end
            end
            S_FETCH: begin
                if (!fifo_empty) begin
                    w_rd_en     = 1'b1;
                    w_rem_nxt   = r_rem - LEN_W'(1);
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // rem was already decremented for this byte, so zero marks the last one.
                w_data_nxt  = fifo_data_out;
                w_valid_nxt = 1'b1;
                w_last_nxt  = (r_rem == '0);
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (r_m_valid && m_ready) begin
                    w_valid_nxt = 1'b0;
                    if (r_m_last) begin
                        w_ok_inc    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_DROP: begin
                if (r_rem == '0) begin
                    w_drop_inc  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (!fifo_empty) begin
                    w_rd_en   = 1'b1;
                    w_rem_nxt = r_rem - LEN_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Saturating frame statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frames_ok   <= '0;
            frames_drop <= '0;
        end else begin
            if (w_ok_inc && (frames_ok != c_cnt_max)) begin
                frames_ok <= frames_ok + CNT_W'(1);
            end
            if (w_drop_inc && (frames_drop != c_cnt_max)) begin
                frames_drop <= frames_drop + CNT_W'(1);
            end
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign m_data     = r_m_data;
    assign m_valid    = r_m_valid;
    assign m_last     = r_m_last;

endmodule
`default_nettype wire
